mvmul_engine: RTL and testbench

- Fixed-size matrix-vector multiplier: computes y = A·x over a shared word-addressed memory, then raises a sticky done flag.
- A (N×N, row-major), x (N) and y (N) all live in one external RAM with two combinational read ports and one write port.
- Runs autonomously from reset release; there is no start input.

---
 rtl/mvmul_engine_if.sv | 24 ++
 rtl/mvmul_engine.sv | 108 ++++++++++
 tb/tb_mvmul_engine.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mvmul_engine_if.sv
// Memory bus between mvmul_engine (master) and its shared word-addressed RAM (slave):
// two combinational read ports plus one clocked write port.
interface mvmul_engine_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] raddr_0;
    logic [DATA_W-1:0] rdata_0;
    logic [ADDR_W-1:0] raddr_1;
    logic [DATA_W-1:0] rdata_1;
    logic [ADDR_W-1:0] waddr_0;
    logic [DATA_W-1:0] wdata_0;
    logic              wen_0;

    modport master (
        output raddr_0, raddr_1, waddr_0, wdata_0, wen_0,
        input  rdata_0, rdata_1
    );

    modport slave (
        input  raddr_0, raddr_1, waddr_0, wdata_0, wen_0,
        output rdata_0, rdata_1
    );
endinterface

// File: rtl/mvmul_engine.sv
// Fixed-size matrix-vector multiplier y = A*x over a shared RAM; sticky valid when done.
// Optional MVMUL_CYCLE_COUNT_EN adds a 16-bit cycle_count output frozen once valid rises.
module mvmul_engine #(
    parameter int N      = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int A_BASE = 0,
    parameter int X_BASE = 9,
    parameter int Y_BASE = 12
) (
    input  logic              clk,
    input  logic              rst,
    mvmul_engine_if.master    mem,
`ifdef MVMUL_CYCLE_COUNT_EN
    output logic [15:0]       cycle_count,
`endif
    output logic              valid
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    typedef enum logic [1:0] {S_READ, S_WRITE, S_DONE} state_t;

    state_t            state;
    logic [IDX_W-1:0]  i;
    logic [IDX_W-1:0]  j;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] prod;
    logic [DATA_W-1:0] acc_next;

    function automatic logic [ADDR_W-1:0] a_addr(input int unsigned row, input int unsigned col);
        return ADDR_W'(A_BASE + row * N + col);
    endfunction

    function automatic logic [ADDR_W-1:0] x_addr(input int unsigned col);
        return ADDR_W'(X_BASE + col);
    endfunction

    function automatic logic [ADDR_W-1:0] y_addr(input int unsigned row);
        return ADDR_W'(Y_BASE + row);
    endfunction

    // Product and sum both wrap modulo 2^DATA_W.
    assign prod     = mem.rdata_0 * mem.rdata_1;
    assign acc_next = acc + prod;

    // Read addresses are registered one step ahead, so they always equal the
    // A/x location for the (i, j) held in the state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_READ;
            i           <= '0;
            j           <= '0;
            acc         <= '0;
            mem.raddr_0 <= ADDR_W'(A_BASE);
            mem.raddr_1 <= ADDR_W'(X_BASE);
            mem.waddr_0 <= ADDR_W'(Y_BASE);
            mem.wdata_0 <= '0;
            mem.wen_0   <= 1'b0;
            valid       <= 1'b0;
        end else begin
            unique case (state)
                S_READ: begin
                    acc <= acc_next;
                    if (j == LAST) begin
                        state       <= S_WRITE;
                        j           <= '0;
                        mem.wen_0   <= 1'b1;
                        mem.waddr_0 <= y_addr(32'(i));
                        mem.wdata_0 <= acc_next;
                        mem.raddr_0 <= a_addr(32'(i), 0);
                        mem.raddr_1 <= x_addr(0);
                    end else begin
                        j           <= j + 1'b1;
                        mem.raddr_0 <= a_addr(32'(i), 32'(j) + 1);
                        mem.raddr_1 <= x_addr(32'(j) + 1);
                    end
                end
                S_WRITE: begin
                    acc       <= '0;
                    mem.wen_0 <= 1'b0;
                    if (i == LAST) begin
                        state <= S_DONE;
                        valid <= 1'b1;
                    end else begin
                        state       <= S_READ;
                        i           <= i + 1'b1;
                        mem.raddr_0 <= a_addr(32'(i) + 1, 0);
                        mem.raddr_1 <= x_addr(0);
                    end
                end
                S_DONE: begin
                end
                default: state <= S_READ;
            endcase
        end
    end

`ifdef MVMUL_CYCLE_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count <= '0;
        end else if (state != S_DONE) begin
            cycle_count <= cycle_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mvmul_engine.sv
// Scoreboarded bench for mvmul_engine: expected writes are queued by the stimulus
// and popped by a write monitor; final memory and valid timing are also checked.
module tb_mvmul_engine;
    localparam int N      = 3;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int A_BASE = 0;
    localparam int X_BASE = 9;
    localparam int Y_BASE = 12;
    localparam int LAT    = N * (N + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic valid;
`ifdef MVMUL_CYCLE_COUNT_EN
    logic [15:0] cycle_count;
`endif

    always #5 clk = ~clk;

    mvmul_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mvmul_engine #(
        .N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .A_BASE(A_BASE), .X_BASE(X_BASE), .Y_BASE(Y_BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem(bus),
`ifdef MVMUL_CYCLE_COUNT_EN
        .cycle_count(cycle_count),
`endif
        .valid(valid)
    );

    logic [31:0] mem [32];
    logic        pre_we = 1'b0;
    logic [4:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    assign bus.rdata_0 = mem[bus.raddr_0];
    assign bus.rdata_1 = mem[bus.raddr_1];

    always @(posedge clk) begin
        if (bus.wen_0) mem[bus.waddr_0] <= bus.wdata_0;
        else if (pre_we) mem[pre_addr] <= pre_data;
    end

    int edge_cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) edge_cnt <= 0;
        else edge_cnt <= edge_cnt + 1;
    end

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t         exp_q [$];
    logic [31:0] exp_y [N];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          wen_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write monitor: each write seen on the bus must match the head of the queue.
    always @(negedge clk) begin
        if (rst && bus.wen_0) begin
            wr_t e;
            wen_pulses++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", bus.waddr_0, bus.wdata_0);
            end else begin
                e = exp_q.pop_front();
                check("waddr_0", 32'(bus.waddr_0), 32'(e.addr));
                check("wdata_0", bus.wdata_0, e.data);
                check("write_cycle", edge_cnt + 1, e.cyc);
            end
        end
    end

    task automatic preload(input logic [31:0] a [N*N], input logic [31:0] x [N]);
        logic [31:0] img [Y_BASE+N];
        for (int k = 0; k < Y_BASE + N; k++) img[k] = $urandom;
        for (int k = 0; k < N * N; k++) img[A_BASE + k] = a[k];
        for (int k = 0; k < N; k++) img[X_BASE + k] = x[k];
        for (int k = 0; k < Y_BASE + N; k++) begin
            @(negedge clk);
            pre_we   = 1'b1;
            pre_addr = 5'(k);
            pre_data = img[k];
        end
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Reference: y[r] = sum_c A[r][c]*x[c] modulo 2^32; row r is committed at edge (r+1)*(N+1).
    task automatic set_expected(input logic [31:0] a [N*N], input logic [31:0] x [N]);
        for (int r = 0; r < N; r++) begin
            logic [31:0] s;
            s = 0;
            for (int c = 0; c < N; c++) s = s + a[r*N + c] * x[c];
            exp_y[r] = s;
            exp_q.push_back('{addr: 5'(Y_BASE + r), data: s, cyc: (r + 1) * (N + 1)});
        end
    endtask

    task automatic reset_checks();
        check("rst_wen_0", 32'(bus.wen_0), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_raddr_0", 32'(bus.raddr_0), A_BASE);
        check("rst_raddr_1", 32'(bus.raddr_1), X_BASE);
        check("rst_waddr_0", 32'(bus.waddr_0), Y_BASE);
        check("rst_wdata_0", bus.wdata_0, 0);
    endtask

    task automatic run_and_check(input int hold);
        @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e <= LAT; e++) begin
            @(posedge clk);
            #1;
            check("valid_timing", 32'(valid), 32'(e == LAT));
        end
`ifdef MVMUL_CYCLE_COUNT_EN
        check("cycle_count_done", 32'(cycle_count), LAT);
`endif
        repeat (hold) @(posedge clk);
        #1;
        check("valid_sticky", 32'(valid), 1);
`ifdef MVMUL_CYCLE_COUNT_EN
        check("cycle_count_frozen", 32'(cycle_count), LAT);
`endif
        for (int r = 0; r < N; r++) check("mem_y", mem[Y_BASE + r], exp_y[r]);
        check("queue_drained", exp_q.size(), 0);
        check("wen_pulses", wen_pulses, N);
    endtask

    logic [31:0] ta [N*N];
    logic [31:0] tx [N];
    logic [31:0] snap [Y_BASE+N];

    initial begin
        repeat (2) @(negedge clk);
        reset_checks();

        // Reference compute
        ta = '{6, 1, 2, 3, 7, 5, 5, 2, 9};
        tx = '{9, 3, 7};
        preload(ta, tx);
        set_expected(ta, tx);
        wen_pulses = 0;
        run_and_check(100);

        // Identity
        @(negedge clk); rst = 1'b0;
        ta = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        tx = '{4, 5, 6};
        preload(ta, tx);
        set_expected(ta, tx);
        wen_pulses = 0;
        run_and_check(5);

        // Wrap-around
        @(negedge clk); rst = 1'b0;
        ta = '{32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0};
        tx = '{2, 0, 0};
        preload(ta, tx);
        set_expected(ta, tx);
        wen_pulses = 0;
        run_and_check(5);
        check("wrap_y0_const", mem[Y_BASE], 32'hFFFF_FFFE);

        // Reset mid-run: abort in row 1, restart with x = [1 1 1]
        @(negedge clk); rst = 1'b0;
        ta = '{6, 1, 2, 3, 7, 5, 5, 2, 9};
        tx = '{9, 3, 7};
        preload(ta, tx);
        set_expected(ta, tx);
        @(negedge clk); rst = 1'b1;
        repeat (6) @(posedge clk);
        #3 rst = 1'b0;
        #1 reset_checks();
        exp_q.delete();
        repeat (2) @(negedge clk);
        tx = '{1, 1, 1};
        preload(ta, tx);
        set_expected(ta, tx);
        wen_pulses = 0;
        run_and_check(5);

        // Idle: reset held, no writes, memory unchanged
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < Y_BASE + N; k++) snap[k] = mem[k];
        wen_pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("idle_wen_0", 32'(bus.wen_0), 0);
            check("idle_valid", 32'(valid), 0);
        end
        for (int k = 0; k < Y_BASE + N; k++) check("idle_mem", mem[k], snap[k]);
        check("idle_wen_pulses", wen_pulses, 0);

        // Randomized matrices, alternating small and full-width operands
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < N * N; k++) ta[k] = (it % 2 == 1) ? $urandom : $urandom_range(0, 255);
            for (int k = 0; k < N; k++) tx[k] = (it % 2 == 1) ? $urandom : $urandom_range(0, 255);
            preload(ta, tx);
            set_expected(ta, tx);
            wen_pulses = 0;
            run_and_check(3);
            @(negedge clk); rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
